// File: rtl/mvma_pkg.sv
// Shared types and width helpers for the matrix-vector multiply-accumulate sequencer.
package mvma_pkg;

    localparam int K_DEF = 4;

    // Address width for a memory of n words, never narrower than one bit.
    function automatic int aw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic [2:0] {
        LOAD_M,
        LOAD_B,
        LOAD_X,
        COMPUTE,
        DRAIN,
        OUT
    } mvma_state_t;

endpackage

// File: rtl/mvma_seq_ctrl_if.sv
// Handshake, memory-control and accumulator-control bundle between the sequencer and its datapath.
interface mvma_seq_ctrl_if #(
    parameter int K = mvma_pkg::K_DEF
);
    import mvma_pkg::*;

    localparam int AW_M = aw_of(K * K);
    localparam int AW_V = aw_of(K);

    logic            s_valid;
    logic            s_ready;
    logic            m_valid;
    logic            m_ready;
    logic            wr_en_m;
    logic            wr_en_b;
    logic            wr_en_x;
    logic [AW_M-1:0] addr_m;
    logic [AW_V-1:0] addr_b;
    logic [AW_V-1:0] addr_x;
    logic            acc_en;
    logic            acc_first;
    logic            acc_clr;
    logic [AW_V-1:0] row_idx;

    modport master (
        input  s_valid, m_ready,
        output s_ready, m_valid, wr_en_m, wr_en_b, wr_en_x,
               addr_m, addr_b, addr_x, acc_en, acc_first, acc_clr, row_idx
    );

    modport slave (
        output s_valid, m_ready,
        input  s_ready, m_valid, wr_en_m, wr_en_b, wr_en_x,
               addr_m, addr_b, addr_x, acc_en, acc_first, acc_clr, row_idx
    );

endinterface

// File: rtl/mvma_rowcol_cnt.sv
// Row/column walk counters for the compute phase plus the row-major matrix address row*K+col.
module mvma_rowcol_cnt #(
    parameter int K    = 4,
    parameter int AW_M = 4,
    parameter int AW_V = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clr,
    input  logic            col_step,
    input  logic            row_step,
    output logic [AW_V-1:0] col,
    output logic [AW_V-1:0] row,
    output logic            col_last,
    output logic            row_last,
    output logic [AW_M-1:0] lin_addr
);

    localparam logic [AW_V-1:0] IDX_LAST = AW_V'(K - 1);

    logic [AW_V-1:0] col_q, col_d;
    logic [AW_V-1:0] row_q, row_d;

    assign col_last = (col_q == IDX_LAST);
    assign row_last = (row_q == IDX_LAST);

    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clr) begin
            col_d = '0;
            row_d = '0;
        end else begin
            if (col_step) col_d = col_last ? '0 : col_q + 1'b1;
            if (row_step) row_d = row_last ? '0 : row_q + 1'b1;
        end
    end

    // NOTE: flops use non-blocking assignments so every register samples the pre-edge values together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col      = col_q;
    assign row      = row_q;
    assign lin_addr = AW_M'(row_q) * AW_M'(K) + AW_M'(col_q);

endmodule

// File: rtl/mvma_seq_ctrl.sv
// Sequencer for y = M*x + b: loads M, b, x over a valid/ready slave port, walks rows, and hands results out.
// The reset input is asynchronous and active-low.
module mvma_seq_ctrl
    import mvma_pkg::*;
#(
    parameter int K    = K_DEF,
    parameter int AW_M = aw_of(K * K),
    parameter int AW_V = aw_of(K)
) (
    input  logic            clk,
    input  logic            reset,
    mvma_seq_ctrl_if.master bus
);

    localparam logic [AW_M-1:0] M_LAST = AW_M'(K * K - 1);
    localparam logic [AW_M-1:0] V_LAST = AW_M'(K - 1);

    mvma_state_t     state_q, state_d;
    logic [AW_M-1:0] cnt_q, cnt_d;
    logic            acc_en_q, acc_en_d;
    logic            acc_first_q, acc_first_d;
    logic            m_valid_q, m_valid_d;

    logic            s_ready, hs, out_hs;
    logic            wr_en_m, wr_en_b, wr_en_x;
    logic [AW_M-1:0] addr_m;
    logic [AW_V-1:0] addr_b, addr_x;

    logic [AW_V-1:0] col, row;
    logic            col_last, row_last;
    logic [AW_M-1:0] lin_addr;

    assign s_ready = reset & (state_q inside {LOAD_M, LOAD_B, LOAD_X});
    assign hs      = bus.s_valid & s_ready;
    assign out_hs  = m_valid_q & bus.m_ready;

    mvma_rowcol_cnt #(
        .K    (K),
        .AW_M (AW_M),
        .AW_V (AW_V)
    ) u_rowcol (
        .clk      (clk),
        .reset    (reset),
        .clr      (wr_en_x & (cnt_q == V_LAST)),
        .col_step (state_q == COMPUTE),
        .row_step ((state_q == OUT) & out_hs),
        .col      (col),
        .row      (row),
        .col_last (col_last),
        .row_last (row_last),
        .lin_addr (lin_addr)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= LOAD_M;
            cnt_q       <= '0;
            acc_en_q    <= 1'b0;
            acc_first_q <= 1'b0;
            m_valid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_en_q    <= acc_en_d;
            acc_first_q <= acc_first_d;
            m_valid_q   <= m_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            LOAD_M: if (hs) begin
                if (cnt_q == M_LAST) begin
                    cnt_d   = '0;
                    state_d = LOAD_B;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LOAD_B: if (hs) begin
                if (cnt_q == V_LAST) begin
                    cnt_d   = '0;
                    state_d = LOAD_X;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LOAD_X: if (hs) begin
                if (cnt_q == V_LAST) begin
                    cnt_d   = '0;
                    state_d = COMPUTE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            COMPUTE: if (col_last) state_d = DRAIN;
            DRAIN:   state_d = OUT;
            OUT:     if (out_hs) state_d = row_last ? LOAD_M : COMPUTE;
            default: state_d = LOAD_M;
        endcase
    end

    // Accumulator controls are registered one cycle behind the issue to line up with the memory read data.
    always_comb begin
        wr_en_m     = 1'b0;
        wr_en_b     = 1'b0;
        wr_en_x     = 1'b0;
        addr_m      = '0;
        addr_b      = '0;
        addr_x      = '0;
        acc_en_d    = 1'b0;
        acc_first_d = 1'b0;
        m_valid_d   = 1'b0;
        case (state_q)
            LOAD_M: begin
                wr_en_m = hs;
                addr_m  = cnt_q;
            end
            LOAD_B: begin
                wr_en_b = hs;
                addr_b  = cnt_q[AW_V-1:0];
            end
            LOAD_X: begin
                wr_en_x = hs;
                addr_x  = cnt_q[AW_V-1:0];
            end
            COMPUTE: begin
                addr_m      = lin_addr;
                addr_x      = col;
                addr_b      = row;
                acc_en_d    = 1'b1;
                acc_first_d = (col == '0);
            end
            DRAIN:   m_valid_d = 1'b1;
            OUT:     m_valid_d = m_valid_q & ~bus.m_ready;
            default: m_valid_d = 1'b0;
        endcase
    end

    assign bus.s_ready   = s_ready;
    assign bus.m_valid   = m_valid_q;
    assign bus.wr_en_m   = wr_en_m;
    assign bus.wr_en_b   = wr_en_b;
    assign bus.wr_en_x   = wr_en_x;
    assign bus.addr_m    = addr_m;
    assign bus.addr_b    = addr_b;
    assign bus.addr_x    = addr_x;
    assign bus.acc_en    = acc_en_q;
    assign bus.acc_first = acc_first_q;
    assign bus.acc_clr   = out_hs;
    assign bus.row_idx   = row;

endmodule

// File: tb/tb_mvma_seq_ctrl.sv
// Self-checking bench for mvma_seq_ctrl: behavioural memories/accumulator around the DUT and a y = M*x + b golden model.
module tb_mvma_seq_ctrl;
    import mvma_pkg::*;

    localparam int K  = 4;
    localparam int NW = K * K + 2 * K;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] din   = '0;

    always #5 clk = ~clk;

    mvma_seq_ctrl_if #(.K(K)) bus ();

    mvma_seq_ctrl #(.K(K)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // External datapath: M/B/X memories with 1-cycle read and the accumulator.
    logic signed [7:0]  mem_m [K*K];
    logic signed [7:0]  mem_b [K];
    logic signed [7:0]  mem_x [K];
    logic signed [7:0]  rd_m, rd_b, rd_x;
    logic signed [15:0] acc, prod, bias_term;

    assign prod      = rd_m * rd_x;
    assign bias_term = bus.acc_first ? rd_b : 16'sd0;

    always @(posedge clk) begin
        if (bus.wr_en_m) mem_m[bus.addr_m] <= din;
        if (bus.wr_en_b) mem_b[bus.addr_b] <= din;
        if (bus.wr_en_x) mem_x[bus.addr_x] <= din;
        rd_m <= mem_m[bus.addr_m];
        rd_b <= mem_b[bus.addr_b];
        rd_x <= mem_x[bus.addr_x];
    end

    always @(posedge clk or negedge reset) begin
        if (!reset)           acc <= '0;
        else if (bus.acc_clr) acc <= '0;
        else if (bus.acc_en)  acc <= acc + prod + bias_term;
    end

    // Monitor: write-enable pulse counts and every accepted result.
    typedef struct {
        int          row;
        logic [15:0] val;
    } res_t;

    res_t res_q[$];
    int   n_wm = 0, n_wb = 0, n_wx = 0;

    always @(posedge clk) begin
        if (bus.wr_en_m) n_wm <= n_wm + 1;
        if (bus.wr_en_b) n_wb <= n_wb + 1;
        if (bus.wr_en_x) n_wx <= n_wx + 1;
        if (bus.m_valid && bus.m_ready) res_q.push_back('{int'(bus.row_idx), acc});
    end

    int total = 0;
    int bad   = 0;
    int g_m [K*K];
    int g_b [K];
    int g_x [K];

    function automatic logic [7:0] word_at(input int i);
        int v;
        if (i < K * K)          v = g_m[i];
        else if (i < K * K + K) v = g_b[i - K * K];
        else                    v = g_x[i - K * K - K];
        return v[7:0];
    endfunction

    function automatic logic [15:0] golden(input int r);
        int s;
        s = g_b[r];
        for (int c = 0; c < K; c++) s += g_m[r * K + c] * g_x[c];
        return s[15:0];
    endfunction

    task automatic rand_batch();
        for (int i = 0; i < K * K; i++) g_m[i] = int'($urandom_range(255)) - 128;
        for (int i = 0; i < K; i++) begin
            g_b[i] = int'($urandom_range(255)) - 128;
            g_x[i] = int'($urandom_range(255)) - 128;
        end
    endtask

    task automatic ident_batch();
        for (int i = 0; i < K * K; i++) g_m[i] = (i / K == i % K) ? 1 : 0;
        for (int i = 0; i < K; i++) begin
            g_b[i] = i + 1;
            g_x[i] = 10 * (i + 1);
        end
    endtask

    // Feeds all NW words; starts and ends just after a falling edge.
    task automatic load_batch(input int sv_pct);
        int          waited;
        bit          done;
        int          e_addr, o_addr;
        logic [2:0]  e_we, o_we;
        for (int i = 0; i < NW; i++) begin
            waited = 0;
            done   = 1'b0;
            while (!done) begin
                bus.s_valid = ($urandom_range(99) < sv_pct);
                bus.m_ready = 1'($urandom_range(1));
                din         = word_at(i);
                #1;
                if (bus.s_valid && bus.s_ready) begin
                    done   = 1'b1;
                    e_we   = (i < K * K) ? 3'b100 : (i < K * K + K) ? 3'b010 : 3'b001;
                    e_addr = (i < K * K) ? i : (i < K * K + K) ? i - K * K : i - K * K - K;
                    o_we   = {bus.wr_en_m, bus.wr_en_b, bus.wr_en_x};
                    o_addr = (i < K * K) ? int'(bus.addr_m) : (i < K * K + K) ? int'(bus.addr_b) : int'(bus.addr_x);
                    total++;
                    if (o_we !== e_we || o_addr != e_addr) begin
                        bad++;
                        $display("FAIL load word %0d: got we=%b addr=%0d, expected we=%b addr=%0d",
                                 i, o_we, o_addr, e_we, e_addr);
                    end
                end
                @(negedge clk);
                waited++;
                if (!done && waited > 200) begin
                    total++;
                    bad++;
                    $display("FAIL load timeout at word %0d: s_ready never seen, expected a handshake", i);
                    bus.s_valid = 1'b0;
                    return;
                end
            end
        end
        bus.s_valid = 1'b0;
    endtask

    // Waits for the rest of the K results of the batch whose first result lands at res_q[base].
    task automatic collect(input int base, input int mr_pct, input int sv_pct);
        int waited, rdy_hits, wr0;
        waited   = 0;
        rdy_hits = 0;
        wr0      = n_wm + n_wb + n_wx;
        while (res_q.size() - base < K && waited < 1000) begin
            bus.m_ready = ($urandom_range(99) < mr_pct);
            bus.s_valid = ($urandom_range(99) < sv_pct);
            #1;
            if (bus.s_ready) rdy_hits++;
            @(negedge clk);
            waited++;
        end
        bus.m_ready = 1'b0;
        bus.s_valid = 1'b0;
        #1;
        total++;
        if (res_q.size() - base < K) begin
            bad++;
            $display("FAIL result count: got %0d, expected %0d", res_q.size() - base, K);
        end
        total++;
        if (rdy_hits != 0) begin
            bad++;
            $display("FAIL s_ready during compute: got %0d cycles high, expected 0", rdy_hits);
        end
        total++;
        if (bus.s_ready !== 1'b1) begin
            bad++;
            $display("FAIL s_ready after batch: got %b, expected 1", bus.s_ready);
        end
        total++;
        if (n_wm + n_wb + n_wx != wr0) begin
            bad++;
            $display("FAIL wr_en outside load: got %0d pulses, expected 0", n_wm + n_wb + n_wx - wr0);
        end
        for (int r = 0; r < K; r++) begin
            if (base + r < res_q.size()) begin
                total++;
                if (res_q[base + r].row != r || res_q[base + r].val !== golden(r)) begin
                    bad++;
                    $display("FAIL result %0d: got row=%0d y=%0d, expected row=%0d y=%0d", r,
                             res_q[base + r].row, $signed(res_q[base + r].val), r, $signed(golden(r)));
                end
            end
        end
    endtask

    task automatic run_batch(input int sv_pct, input int mr_pct);
        int s_m, s_b, s_x, base;
        s_m  = n_wm;
        s_b  = n_wb;
        s_x  = n_wx;
        base = res_q.size();
        load_batch(sv_pct);
        collect(base, mr_pct, sv_pct);
        total++;
        if (n_wm - s_m != K * K || n_wb - s_b != K || n_wx - s_x != K) begin
            bad++;
            $display("FAIL wr_en counts: got m/b/x=%0d/%0d/%0d, expected %0d/%0d/%0d",
                     n_wm - s_m, n_wb - s_b, n_wx - s_x, K * K, K, K);
        end
    endtask

    // Six cycles of a row starting at its first issue: addresses, enables, m_valid rise after K+1 cycles.
    task automatic trace_row(input int r);
        logic [16:0] obs, exp_v;
        bit          in_issue;
        for (int j = 0; j <= K + 1; j++) begin
            bus.m_ready = 1'b0;
            bus.s_valid = 1'b1;
            #1;
            in_issue = (j < K);
            exp_v = {4'(in_issue ? r * K + j : 0), 2'(in_issue ? j : 0), 2'(in_issue ? r : 0),
                     (j >= 1 && j <= K), (j == 1), (j == K + 1), 1'b0, 3'b000, 2'(r)};
            obs   = {bus.addr_m, bus.addr_x, bus.addr_b, bus.acc_en, bus.acc_first, bus.m_valid,
                     bus.acc_clr, bus.wr_en_m, bus.wr_en_b, bus.wr_en_x, bus.row_idx};
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL trace row %0d cycle %0d: got %h, expected %h", r, j, obs, exp_v);
            end
            if (j <= K) @(negedge clk);
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic test_reset();
        bus.s_valid = 1'b1;
        bus.m_ready = 1'b1;
        reset       = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if ({bus.s_ready, bus.m_valid, bus.acc_en, bus.acc_first, bus.acc_clr,
             bus.wr_en_m, bus.wr_en_b, bus.wr_en_x} !== 8'h00) begin
            bad++;
            $display("FAIL reset controls: got %b%b%b%b%b%b%b%b, expected 00000000", bus.s_ready, bus.m_valid,
                     bus.acc_en, bus.acc_first, bus.acc_clr, bus.wr_en_m, bus.wr_en_b, bus.wr_en_x);
        end
        total++;
        if ({bus.addr_m, bus.addr_b, bus.addr_x, bus.row_idx} !== 10'h000) begin
            bad++;
            $display("FAIL reset addresses: got %h, expected 000", {bus.addr_m, bus.addr_b, bus.addr_x, bus.row_idx});
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++;
        if ({bus.s_ready, bus.wr_en_m, bus.addr_m} !== {2'b11, 4'd0}) begin
            bad++;
            $display("FAIL post-reset LOAD_M: got s_ready=%b wr_en_m=%b addr_m=%0d, expected 1 1 0",
                     bus.s_ready, bus.wr_en_m, bus.addr_m);
        end
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        ident_batch();
        run_batch(100, 100);
    endtask

    task automatic test_timing_stall();
        int base, hits;
        rand_batch();
        base = res_q.size();
        load_batch(100);
        trace_row(0);
        hits = 0;
        repeat (10) begin
            @(negedge clk);
            bus.m_ready = 1'b0;
            bus.s_valid = 1'b1;
            #1;
            if (!bus.m_valid || bus.acc_en || bus.acc_clr || bus.row_idx != 0 ||
                bus.wr_en_m || bus.wr_en_b || bus.wr_en_x) hits++;
        end
        total++;
        if (hits != 0) begin
            bad++;
            $display("FAIL stall hold: got %0d bad cycles, expected 0", hits);
        end
        bus.m_ready = 1'b1;
        #1;
        total++;
        if (bus.acc_clr !== 1'b1) begin
            bad++;
            $display("FAIL acc_clr on release: got %b, expected 1", bus.acc_clr);
        end
        @(negedge clk);
        trace_row(1);
        collect(base, 100, 50);
    endtask

    task automatic test_gaps();
        for (int n = 0; n < 2; n++) begin
            rand_batch();
            run_batch(50, 50);
        end
    endtask

    task automatic test_reset_mid();
        int base, waited, hits;
        rand_batch();
        base = res_q.size();
        load_batch(100);
        waited = 0;
        while (res_q.size() - base < 2 && waited < 200) begin
            bus.m_ready = 1'b1;
            #1;
            @(negedge clk);
            waited++;
        end
        bus.m_ready = 1'b0;
        bus.s_valid = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if ({bus.acc_en, bus.row_idx} !== {1'b1, 2'(2)}) begin
            bad++;
            $display("FAIL pre-reset row 2: got acc_en=%b row=%0d, expected 1 2", bus.acc_en, bus.row_idx);
        end
        reset = 1'b0;
        #1;
        total++;
        if ({bus.m_valid, bus.acc_en, bus.acc_first, bus.s_ready, bus.acc_clr,
             bus.wr_en_m, bus.wr_en_b, bus.wr_en_x} !== 8'h00) begin
            bad++;
            $display("FAIL mid-compute reset: got mv=%b en=%b rdy=%b wr=%b%b%b, expected all 0", bus.m_valid,
                     bus.acc_en, bus.s_ready, bus.wr_en_m, bus.wr_en_b, bus.wr_en_x);
        end
        total++;
        if ({bus.addr_m, bus.addr_b, bus.addr_x, bus.row_idx} !== 10'h000) begin
            bad++;
            $display("FAIL mid-compute reset addresses: got %h, expected 000",
                     {bus.addr_m, bus.addr_b, bus.addr_x, bus.row_idx});
        end
        hits = 0;
        repeat (3) begin
            @(negedge clk);
            #1;
            if (bus.s_ready || bus.wr_en_m) hits++;
        end
        total++;
        if (hits != 0) begin
            bad++;
            $display("FAIL s_ready while reset low: got %0d cycles high, expected 0", hits);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++;
        if (bus.s_ready !== 1'b1) begin
            bad++;
            $display("FAIL s_ready after reset release: got %b, expected 1", bus.s_ready);
        end
        bus.s_valid = 1'b0;
        @(negedge clk);

        // Abort while a result is being presented.
        rand_batch();
        load_batch(100);
        bus.m_ready = 1'b0;
        waited = 0;
        while (!bus.m_valid && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if (bus.m_valid !== 1'b1) begin
            bad++;
            $display("FAIL reach OUT: got m_valid=%b, expected 1", bus.m_valid);
        end
        reset = 1'b0;
        #1;
        total++;
        if ({bus.m_valid, bus.acc_clr, bus.s_ready} !== 3'b000) begin
            bad++;
            $display("FAIL reset in OUT: got mv=%b clr=%b rdy=%b, expected 0 0 0",
                     bus.m_valid, bus.acc_clr, bus.s_ready);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        rand_batch();
        run_batch(100, 100);
    endtask

    task automatic test_back_to_back();
        int base;
        base = res_q.size();
        for (int n = 0; n < 10; n++) begin
            rand_batch();
            run_batch(int'($urandom_range(100, 30)), int'($urandom_range(100, 30)));
        end
        total++;
        if (res_q.size() - base != 10 * K) begin
            bad++;
            $display("FAIL back-to-back result total: got %0d, expected %0d", res_q.size() - base, 10 * K);
        end
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;
        test_reset();
        test_basic();
        test_timing_stall();
        test_gaps();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mvma_seq_ctrl.md
Name: mvma_seq_ctrl

Overview:
Sequencer for the K×K matrix-vector multiply-accumulate datapath (y = M·x + b, 8-bit signed operands, 16-bit accumulator). Accepts a batch of K·K matrix words, then K bias words, then K vector words through a valid/ready slave port, writing them into the M/B/X memories. It then walks the memories row by row, driving the accumulator enables, and presents each row result on a valid/ready master port. It holds all addresses, write enables and handshake state; the memories and accumulator are external.

Parameters:
K, 4, matrix dimension
AW_M, $clog2(K*K), matrix memory address width (minimum 1)
AW_V, $clog2(K), bias/vector memory address width (minimum 1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
s_valid  in  1  input word valid
s_ready  out  1  controller accepts input word
m_ready  in  1  downstream accepts result
m_valid  out  1  result on datapath output is valid
wr_en_m  out  1  matrix memory write enable
wr_en_b  out  1  bias memory write enable
wr_en_x  out  1  vector memory write enable
addr_m  out  AW_M  matrix memory address
addr_b  out  AW_V  bias memory address
addr_x  out  AW_V  vector memory address
acc_en  out  1  datapath: acc <= acc + m·x (+b when acc_first)
acc_first  out  1  first term of a row; datapath adds bias
acc_clr  out  1  clear accumulator and overflow flag
row_idx  out  AW_V  row currently computed/presented

Behaviour:
- States: LOAD_M, LOAD_B, LOAD_X, COMPUTE, DRAIN, OUT. Counters: cnt (AW_M), col (AW_V), row (AW_V).
- Reset low, asynchronously: state=LOAD_M; cnt=col=row=0; m_valid=acc_en=acc_first=0; s_ready=0 while reset is low.
- s_ready = 1 exactly in the LOAD_* states with reset high.
- A handshake is s_valid & s_ready.
- Write enables are combinational: wr_en_m = handshake in LOAD_M; wr_en_b = handshake in LOAD_B; wr_en_x = handshake in LOAD_X. All are 0 in every other state.
- LOAD_M: addr_m=cnt. On handshake cnt++. On the handshake with cnt==K*K-1: cnt=0, go to LOAD_B.
- LOAD_B: addr_b=cnt[AW_V-1:0]. On the handshake with cnt==K-1: cnt=0, go to LOAD_X.
- LOAD_X: addr_x=cnt. On the handshake with cnt==K-1: cnt=0, row=0, col=0, go to COMPUTE.
- s_valid low leaves every counter and the state unchanged. data_in is never consumed outside a handshake.
- COMPUTE, one issue per cycle: addr_m=row*K+col, addr_x=col, addr_b=row; col++. At col==K-1: col=0, go to DRAIN.
- Memory read latency is 1 cycle, so acc_en and acc_first are registered copies of the issue: acc_en=1 the cycle after each issue, and acc_first=1 with the acc_en of col 0.
- DRAIN: one cycle, carrying the final acc_en, then go to OUT.
- OUT: m_valid=1 (registered), held until m_ready.
  - acc_clr = m_valid & m_ready (combinational).
  - On that handshake, if row==K-1: row=0, go to LOAD_M. Otherwise row++ and go to COMPUTE.
- Latency: m_valid rises K+1 cycles after the final x handshake edge. The next row's m_valid rises K+1 cycles after the previous result handshake.
- m_ready low in OUT: stall. State, addresses and m_valid are held; acc_en=0.
- m_ready and s_valid are ignored outside OUT and the LOAD_* states respectively.
- row_idx=row in every state.
- Reset asserted mid-operation (any state) aborts the batch immediately. The next batch starts from LOAD_M with no residual writes or enables.
- Outside its active state, each address output is 0.

Decomposition:
- Package mvma_pkg holds: K default, the AW_M/AW_V derivation function, and the enum type mvma_state_t {LOAD_M, LOAD_B, LOAD_X, COMPUTE, DRAIN, OUT}.
- One natural sub-module, mvma_rowcol_cnt: the row/col counters with a wrap flag and the row*K+col address generation.

Test Plan:
- Reset, then 24 words with s_valid=1 and m_ready=1. M=identity, b={1,2,3,4}, x={10,20,30,40}. Required:
  - wr_en_m/b/x pulse exactly 16/4/4 times.
  - Results 11,22,33,44, with row_idx 0..3.
  - s_ready=0 from the 24th handshake until the 4th result handshake.
- Timing: after the 24th handshake, m_valid rises exactly 5 cycles later. Row 0 addr_m sequence is 0,1,2,3. acc_en runs for 4 cycles, with acc_first only on the first.
- m_ready=0 for 10 cycles in OUT: m_valid stays 1, acc_en=0, acc_clr=0. Releasing m_ready gives a single acc_clr pulse, and the next m_valid follows 5 cycles later.
- Random s_valid gaps (50%): counters advance only on handshakes. s_valid=1 during COMPUTE/DRAIN/OUT produces no wr_en.
- Reset pulled low mid-COMPUTE of row 2: m_valid=0 and acc_en=0 immediately; s_ready=0 while low, 1 after release. A fresh 24-word batch then produces correct results.
- Ten back-to-back batches (240 words, random s_valid/m_ready): 40 results in order, matching the golden model.
